// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and FSM encoding for the SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    // Clock polarity/phase mode supported by the master (mode 0 only).
    localparam int unsigned SPI_MODE    = 0;
    // Bits per byte and SCLK toggles needed to move one byte.
    localparam int unsigned SPI_BITS    = 8;
    localparam int unsigned SPI_TOGGLES = 2 * SPI_BITS;
    localparam int unsigned SPI_TGL_W   = $clog2(SPI_TOGGLES);

    // Transfer state machine encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_clkdiv.sv
// ============================================================================
//  Module      : spi_clkdiv
//  Description : Loadable half-period divider. Counts 0..div while enabled
//                and flags the terminal count, then wraps to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clkdiv #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    // Terminal count: compare-equal, so div at full scale never overflows.
    assign tc_o = en_i && (cnt_q == div_q);

    // Next counter value: a load restarts the period, otherwise count and wrap.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (load_i) begin
            cnt_d = '0;
            div_d = div_i;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter and latched divider setting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
//  Module      : spi_master
//  Description : Byte-streaming SPI mode-0 master with one-hot active-low
//                chip selects and frame support (CS held between bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int CS_W  = 1,
    parameter int IO_W  = 0,
    parameter int DIV_W = 8
) (
    input  logic             s_clk_i,
    input  logic             s_rst_i,
    input  logic [DIV_W-1:0] s_div_i,
    input  logic [IO_W:0]    s_io_cfg_i,
    input  logic             s_tx_valid_i,
    output logic             s_tx_ready_o,
    input  logic [7:0]       s_tx_data_i,
    input  logic [CS_W:0]    s_tx_cs_i,
    input  logic             s_tx_last_i,
    output logic             s_rx_valid_o,
    output logic [7:0]       s_rx_data_o,
    input  logic             s_spi_miso_i,
    output logic             s_busy_o,
    output logic             s_spi_clk_o,
    output logic             s_spi_dat_o,
    output logic [CS_W:0]    s_spi_cs_o,
    output logic [IO_W:0]    s_spi_io_o
);

    state_e                state_q, state_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [CS_W:0]         cs_q, cs_d;
    logic [SPI_BITS-1:0]   tx_q, tx_d;
    logic [SPI_BITS-1:0]   rx_q, rx_d;
    logic [SPI_BITS-1:0]   rxdat_q, rxdat_d;
    logic                  rxv_q, rxv_d;
    logic                  last_q, last_d;
    logic [SPI_TGL_W-1:0]  tgl_q, tgl_d;

    logic                  accept;
    logic                  div_en;
    logic                  div_tc;

    assign s_tx_ready_o = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign accept       = s_tx_valid_i && s_tx_ready_o;
    assign s_busy_o     = (state_q != ST_IDLE);
    assign s_spi_io_o   = s_io_cfg_i;
    assign s_spi_clk_o  = sclk_q;
    assign s_spi_dat_o  = mosi_q;
    assign s_spi_cs_o   = cs_q;
    assign s_rx_valid_o = rxv_q;
    assign s_rx_data_o  = rxdat_q;

    // The divider paces every timed state; any accept restarts its period.
    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    spi_clkdiv #(
        .DIV_W (DIV_W)
    ) u_clkdiv (
        .clk_i  (s_clk_i),
        .rst_i  (s_rst_i),
        .load_i (accept),
        .en_i   (div_en),
        .div_i  (s_div_i),
        .tc_o   (div_tc)
    );

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxdat_d = rxdat_q;
        rxv_d   = 1'b0;
        last_d  = last_q;
        tgl_d   = tgl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_d    = s_tx_data_i;
                    last_d  = s_tx_last_i;
                    cs_d    = ~s_tx_cs_i;
                    mosi_d  = s_tx_data_i[SPI_BITS-1];
                    tgl_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_tc) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_tc) begin
                    sclk_d = ~sclk_q;
                    tgl_d  = tgl_q + 1'b1;
                    if (!sclk_q) begin
                        // Rising edge: capture MISO.
                        rx_d = {rx_q[SPI_BITS-2:0], s_spi_miso_i};
                    end else begin
                        // Falling edge: present the next MOSI bit.
                        tx_d   = {tx_q[SPI_BITS-2:0], 1'b0};
                        mosi_d = tx_q[SPI_BITS-2];
                        if (tgl_q == SPI_TGL_W'(SPI_TOGGLES - 1)) begin
                            rxv_d   = 1'b1;
                            rxdat_d = rx_q;
                            state_d = last_q ? ST_HOLD : ST_WAIT;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (div_tc) begin
                    cs_d    = '1;
                    mosi_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Next byte of the frame: CS stays as latched on the first byte.
                if (accept) begin
                    tx_d    = s_tx_data_i;
                    last_d  = s_tx_last_i;
                    mosi_d  = s_tx_data_i[SPI_BITS-1];
                    tgl_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state_q <= ST_IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            tx_q    <= '0;
            rx_q    <= '0;
            rxdat_q <= '0;
            rxv_q   <= 1'b0;
            last_q  <= 1'b0;
            tgl_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxdat_q <= rxdat_d;
            rxv_q   <= rxv_d;
            last_q  <= last_d;
            tgl_q   <= tgl_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
//  Module      : tb_spi_master
//  Description : Directed self-checking bench for spi_master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] div = 8'd0;
    logic [0:0] io_cfg = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'd0;
    logic [1:0] tx_cs = 2'b00;
    logic       tx_last = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       miso;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic [1:0] cs;
    logic [0:0] io;

    // Bench-side device: loopback or fixed response byte.
    logic       loop_en = 1'b1;
    logic [7:0] dev_val = 8'h00;
    logic [2:0] dev_idx;

    // Monitor state.
    logic       mon_clr = 1'b0;
    logic       sclk_prev, cs_was_low;
    int         rise_cnt, rxv_cnt, cs_low_cnt, cs_rel_cnt, mosi_hi_cnt;
    int         hi_run, min_hi, max_hi, gap, min_gap, have_rise;
    int         mbits;
    logic [7:0] msh, mbyte0, mbyte1, rxb0, rxb1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign miso = loop_en ? mosi : dev_val[3'd7 - dev_idx];

    spi_master #(
        .CS_W  (1),
        .IO_W  (0),
        .DIV_W (8)
    ) dut (
        .s_clk_i      (clk),
        .s_rst_i      (rst),
        .s_div_i      (div),
        .s_io_cfg_i   (io_cfg),
        .s_tx_valid_i (tx_valid),
        .s_tx_ready_o (tx_ready),
        .s_tx_data_i  (tx_data),
        .s_tx_cs_i    (tx_cs),
        .s_tx_last_i  (tx_last),
        .s_rx_valid_o (rx_valid),
        .s_rx_data_o  (rx_data),
        .s_spi_miso_i (miso),
        .s_busy_o     (busy),
        .s_spi_clk_o  (sclk),
        .s_spi_dat_o  (mosi),
        .s_spi_cs_o   (cs),
        .s_spi_io_o   (io)
    );

    // Pin-level monitor: edges, run lengths, CS activity, captured bytes.
    always @(posedge clk) begin
        if (mon_clr) begin
            sclk_prev <= 1'b0; cs_was_low <= 1'b0;
            rise_cnt <= 0; rxv_cnt <= 0; cs_low_cnt <= 0; cs_rel_cnt <= 0;
            mosi_hi_cnt <= 0; hi_run <= 0; min_hi <= 255; max_hi <= 0;
            gap <= 0; min_gap <= 255; have_rise <= 0; mbits <= 0;
            msh <= 8'd0; mbyte0 <= 8'd0; mbyte1 <= 8'd0;
            rxb0 <= 8'd0; rxb1 <= 8'd0; dev_idx <= 3'd0;
        end else begin
            sclk_prev  <= sclk;
            cs_was_low <= (cs != 2'b11);
            if (cs != 2'b11) cs_low_cnt <= cs_low_cnt + 1;
            if (cs == 2'b11 && cs_was_low) cs_rel_cnt <= cs_rel_cnt + 1;
            if (busy && mosi) mosi_hi_cnt <= mosi_hi_cnt + 1;
            if (rx_valid) begin
                rxv_cnt <= rxv_cnt + 1;
                rxb1 <= rxb0;
                rxb0 <= rx_data;
            end
            if (sclk) begin
                hi_run <= hi_run + 1;
            end else if (sclk_prev) begin
                if (hi_run < min_hi) min_hi <= hi_run;
                if (hi_run > max_hi) max_hi <= hi_run;
                hi_run <= 0;
            end
            if (sclk && !sclk_prev) begin
                rise_cnt <= rise_cnt + 1;
                dev_idx  <= dev_idx + 3'd1;
                if (have_rise != 0 && gap < min_gap) min_gap <= gap;
                have_rise <= 1;
                gap <= 1;
                msh <= {msh[6:0], mosi};
                if (mbits == 7) begin
                    mbyte1 <= mbyte0;
                    mbyte0 <= {msh[6:0], mosi};
                    mbits  <= 0;
                end else begin
                    mbits <= mbits + 1;
                end
            end else begin
                gap <= gap + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    // Offer one byte and return right after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic l, input logic [7:0] dv);
        int n;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d; tx_cs = m; tx_last = l; div = dv;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'hEE; tx_cs = 2'b11; tx_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        logic hit;

        // Reset state.
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; mon_clr = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_cs",    32'(cs),       32'h3);
        check("rst_sclk",  32'(sclk),     32'd0);
        check("rst_mosi",  32'(mosi),     32'd0);
        check("rst_rxv",   32'(rx_valid), 32'd0);
        check("rst_rxd",   32'(rx_data),  32'h00);
        io_cfg = 1'b1; #1;
        check("io_pass1", 32'(io), 32'd1);
        io_cfg = 1'b0; #1;
        check("io_pass0", 32'(io), 32'd0);

        // div=0, 0xA5 single byte, loopback.
        loop_en = 1'b1;
        clear_mon();
        send(8'hA5, 2'b01, 1'b1, 8'd0);
        drop_valid();
        check("a5_cs_sel", 32'(cs), 32'h2);
        check("a5_busy",   32'(busy), 32'd1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("a5_rises",   32'(rise_cnt),   32'd8);
        check("a5_rxcnt",   32'(rxv_cnt),    32'd1);
        check("a5_rxdata",  32'(rx_data),    32'hA5);
        check("a5_cslow",   32'(cs_low_cnt), 32'd18);
        check("a5_mosi",    32'(mbyte0),     32'hA5);
        check("a5_hirun",   32'(max_hi),     32'd1);
        check("a5_cs_idle", 32'(cs),         32'h3);

        // div=3, mask 2'b10, two-byte frame.
        clear_mon();
        send(8'h3C, 2'b10, 1'b0, 8'd3);
        send(8'hF0, 2'b01, 1'b1, 8'd3);
        drop_valid();
        check("fr_cs_sel", 32'(cs), 32'h1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("fr_rxcnt",  32'(rxv_cnt),    32'd2);
        check("fr_rx0",    32'(rxb1),       32'h3C);
        check("fr_rx1",    32'(rxb0),       32'hF0);
        check("fr_csrel",  32'(cs_rel_cnt), 32'd1);
        check("fr_minhi",  32'(min_hi),     32'd4);
        check("fr_maxhi",  32'(max_hi),     32'd4);
        check("fr_period", 32'(min_gap),    32'd8);
        check("fr_rises",  32'(rise_cnt),   32'd16);

        // Device returns 0x5A while 0x00 is sent.
        loop_en = 1'b0; dev_val = 8'h5A;
        clear_mon();
        send(8'h00, 2'b01, 1'b1, 8'd1);
        drop_valid();
        wait_idle();
        repeat (2) @(negedge clk);
        check("dev_rx",   32'(rx_data),     32'h5A);
        check("dev_mosi", 32'(mosi_hi_cnt), 32'd0);
        check("dev_cnt",  32'(rxv_cnt),     32'd1);

        // Reset after the third rising SCLK.
        loop_en = 1'b1;
        clear_mon();
        send(8'hFF, 2'b01, 1'b1, 8'd2);
        drop_valid();
        n = 0;
        while (rise_cnt < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("rst3_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_cs",    32'(cs),       32'h3);
        check("mid_sclk",  32'(sclk),     32'd0);
        check("mid_ready", 32'(tx_ready), 32'd1);
        check("mid_busy",  32'(busy),     32'd0);
        check("mid_rxd",   32'(rx_data),  32'h00);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_norx",  32'(rxv_cnt),  32'd0);

        // Stall in WAIT for 100 cycles.
        send(8'h11, 2'b01, 1'b0, 8'd1);
        drop_valid();
        n = 0;
        while (!(tx_ready && busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("wait_timeout", 32'd0, 32'd1);
        clear_mon();
        repeat (100) @(negedge clk);
        check("wait_rises", 32'(rise_cnt), 32'd0);
        check("wait_cs",    32'(cs),       32'h2);
        check("wait_busy",  32'(busy),     32'd1);
        check("wait_sclk",  32'(sclk),     32'd0);
        send(8'h22, 2'b10, 1'b1, 8'd1);
        drop_valid();
        wait_idle();
        check("wait_end_cs", 32'(cs), 32'h3);

        // Valid held high with churning data while busy.
        clear_mon();
        send(8'h81, 2'b01, 1'b0, 8'd0);
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                tx_data = 8'h42; tx_last = 1'b1; tx_cs = 2'b10;
                @(posedge clk);
                hit = 1'b1;
                break;
            end else begin
                tx_data = 8'($urandom);
                tx_last = 1'($urandom);
                tx_cs   = 2'($urandom);
            end
        end
        check("churn_accept", 32'(hit), 32'd1);
        drop_valid();
        wait_idle();
        repeat (5) @(negedge clk);
        check("churn_b0",  32'(mbyte1),  32'h81);
        check("churn_b1",  32'(mbyte0),  32'h42);
        check("churn_rx",  32'(rxv_cnt), 32'd2);
        check("churn_hold", 32'(rx_data), 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
